// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW result path: FSM state encoding, record word
// indices and the saturating counter helper used by the optional statistics.
package dtw_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAP_QID  = 3'd1,
        WAIT_POS = 3'd2,
        CAP_POS  = 3'd3,
        WAIT_MIN = 3'd4,
        CAP_MIN  = 3'd5,
        EVAL     = 3'd6,
        EMIT     = 3'd7
    } dtw_state_e;

    localparam int REC_QID = 0;
    localparam int REC_POS = 1;
    localparam int REC_MIN = 2;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_AXIS_WIDTH = 32;
    localparam int HIT_BIT        = DEF_AXIS_WIDTH - 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dtw_result_filter_if.sv
// AXI-Stream beat bundle carrying result packets toward the DMA/host side.
interface dtw_result_filter_if #(
    parameter int AXIS_WIDTH = 32
);
    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dtw_axis_beat_reg.sv
// One-entry AXI-Stream output register: holds tdata/tlast stable while the
// downstream stalls, and reports when the held beat is taken.
module dtw_axis_beat_reg #(
    parameter int AXIS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [AXIS_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  accept,
    dtw_result_filter_if.master   m_axis
);

    logic [AXIS_WIDTH-1:0] tdata_reg;
    logic                  tvalid_reg;
    logic                  tlast_reg;

    assign accept = tvalid_reg & m_axis.tready;

    // The owner may only load while empty or in the cycle the held beat leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (load) begin
            tdata_reg  <= load_data;
            tvalid_reg <= 1'b1;
            tlast_reg  <= load_last;
        end else if (accept) begin
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end
    end

    assign m_axis.tdata  = tdata_reg;
    assign m_axis.tvalid = tvalid_reg;
    assign m_axis.tlast  = tlast_reg;

endmodule

// File: rtl/dtw_result_filter.sv
// Drains 3-word DTW result records from the core FIFO, classifies hit/miss
// against a threshold and emits 3-beat AXI-Stream packets. Optional counters: DTW_RESULT_STATS_EN.
module dtw_result_filter
    import dtw_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int AXIS_WIDTH = 32,
    parameter int DROP_MISS  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      threshold,
    output logic                  res_fifo_rden,
    input  logic                  res_fifo_empty,
    input  logic [AXIS_WIDTH-1:0] res_fifo_data,
    dtw_result_filter_if.master   m_axis,
    output logic                  busy
`ifdef DTW_RESULT_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    dtw_state_e            state_reg, state_next;
    logic [1:0]            beat_idx_reg, beat_idx_next;
    logic                  hit_reg;
    logic                  hit;
    logic [2:0]            cap_sel;
    logic [AXIS_WIDTH-1:0] rec_word [3];
    logic [AXIS_WIDTH-1:0] min_beat;
    logic                  beat_load;
    logic [AXIS_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic                  beat_accept;

    assign cap_sel = {state_reg == CAP_MIN, state_reg == CAP_POS, state_reg == CAP_QID};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rec
            logic [AXIS_WIDTH-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (cap_sel[gi]) begin
                    word_reg <= res_fifo_data;
                end
            end
            assign rec_word[gi] = word_reg;
        end
    endgenerate

    // Upper bits of the third word are don't-care; only minval is compared.
    assign hit      = (rec_word[REC_MIN][WIDTH-1:0] <= threshold);
    assign min_beat = {hit_reg, {(AXIS_WIDTH-WIDTH-1){1'b0}}, rec_word[REC_MIN][WIDTH-1:0]};
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_idx_reg <= 2'd0;
            hit_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_idx_reg <= beat_idx_next;
            if (state_reg == EVAL) begin
                hit_reg <= hit;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_idx_next = beat_idx_reg;
        res_fifo_rden = 1'b0;
        beat_load     = 1'b0;
        beat_data     = '0;
        beat_last     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && !res_fifo_empty) begin
                    res_fifo_rden = 1'b1;
                    state_next    = CAP_QID;
                end
            end
            CAP_QID: begin
                res_fifo_rden = !res_fifo_empty;
                state_next    = res_fifo_empty ? WAIT_POS : CAP_POS;
            end
            WAIT_POS: begin
                if (!res_fifo_empty) begin
                    res_fifo_rden = 1'b1;
                    state_next    = CAP_POS;
                end
            end
            CAP_POS: begin
                res_fifo_rden = !res_fifo_empty;
                state_next    = res_fifo_empty ? WAIT_MIN : CAP_MIN;
            end
            WAIT_MIN: begin
                if (!res_fifo_empty) begin
                    res_fifo_rden = 1'b1;
                    state_next    = CAP_MIN;
                end
            end
            CAP_MIN: state_next = EVAL;
            EVAL: begin
                if (DROP_MISS != 0 && !hit) begin
                    state_next = IDLE;
                end else begin
                    beat_load     = 1'b1;
                    beat_data     = rec_word[REC_QID];
                    beat_idx_next = 2'd0;
                    state_next    = EMIT;
                end
            end
            EMIT: begin
                if (beat_accept) begin
                    if (beat_idx_reg == 2'd2) begin
                        state_next = IDLE;
                    end else begin
                        beat_load     = 1'b1;
                        beat_idx_next = beat_idx_reg + 2'd1;
                        if (beat_idx_reg == 2'd0) begin
                            beat_data = rec_word[REC_POS];
                        end else begin
                            beat_data = min_beat;
                            beat_last = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    dtw_axis_beat_reg #(
        .AXIS_WIDTH(AXIS_WIDTH)
    ) u_beat (
        .clk       (clk),
        .rst       (rst),
        .load      (beat_load),
        .load_data (beat_data),
        .load_last (beat_last),
        .accept    (beat_accept),
        .m_axis    (m_axis)
    );

`ifdef DTW_RESULT_STATS_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    // Every record passes EVAL exactly once, dropped misses included.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= 32'd0;
            miss_count_reg <= 32'd0;
        end else if (state_reg == EVAL) begin
            if (hit) begin
                hit_count_reg <= sat_inc(hit_count_reg);
            end else begin
                miss_count_reg <= sat_inc(miss_count_reg);
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_dtw_result_filter.sv
// Bench for dtw_result_filter: FIFO model plus beat scoreboard, one emitting
// instance (DROP_MISS=0) and one dropping instance (DROP_MISS=1).
`timescale 1ns/1ps
module tb_dtw_result_filter;

    localparam int WIDTH = 16;
    localparam int AW    = 32;

    typedef struct {
        logic [AW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0]    qid;
        logic [AW-1:0]    pos;
        logic [AW-1:0]    mword;
        logic [WIDTH-1:0] thr;
        logic [AW-1:0]    third;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] threshold = '0;
    logic             rden0, rden1, busy0, busy1;
    logic             empty0 = 1'b1, empty1 = 1'b1;
    logic [AW-1:0]    rdata0 = '0, rdata1 = '0;
`ifdef DTW_RESULT_STATS_EN
    logic [31:0]      hit0, miss0, hit1, miss1;
`endif

    always #5 clk = ~clk;

    dtw_result_filter_if #(.AXIS_WIDTH(AW)) ax0 ();
    dtw_result_filter_if #(.AXIS_WIDTH(AW)) ax1 ();

    dtw_result_filter #(.WIDTH(WIDTH), .AXIS_WIDTH(AW), .DROP_MISS(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .threshold(threshold),
        .res_fifo_rden(rden0), .res_fifo_empty(empty0), .res_fifo_data(rdata0),
        .m_axis(ax0), .busy(busy0)
`ifdef DTW_RESULT_STATS_EN
        , .hit_count(hit0), .miss_count(miss0)
`endif
    );

    dtw_result_filter #(.WIDTH(WIDTH), .AXIS_WIDTH(AW), .DROP_MISS(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .threshold(threshold),
        .res_fifo_rden(rden1), .res_fifo_empty(empty1), .res_fifo_data(rdata1),
        .m_axis(ax1), .busy(busy1)
`ifdef DTW_RESULT_STATS_EN
        , .hit_count(hit1), .miss_count(miss1)
`endif
    );

    logic [AW-1:0] fq0[$];
    logic [AW-1:0] fq1[$];
    beat_t         exp0[$];
    beat_t         exp1[$];
    int            total = 0;
    int            bad = 0;
    logic          rd0 = 1'b0, rd1 = 1'b0, mv0 = 1'b0;
    logic          pv0 = 1'b0, pr0 = 1'b0, plast0 = 1'b0;
    logic [AW-1:0] pdata0 = '0;
    int            hs0 = 0, hs1 = 0, stall = 0;
    logic          bp = 1'b0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic score(input int inst, input logic [AW-1:0] data, input logic last);
        beat_t e;
        if (inst == 0 ? exp0.size() == 0 : exp1.size() == 0) begin
            flag($sformatf("unexpected_beat inst%0d data=0x%08h", inst, data));
        end else begin
            e = (inst == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("beat_data inst%0d", inst), data, e.data);
            check($sformatf("beat_last inst%0d", inst), {31'd0, last}, {31'd0, e.last});
        end
        $display("beat inst%0d data=0x%08h last=%0d", inst, data, last);
    endtask

    // Monitor at negedge, then advance FIFO model and tready at posedge+1.
    task automatic tick();
        @(negedge clk);
        if (rden0 && empty0) flag("rden0_while_empty");
        if (rden1 && empty1) flag("rden1_while_empty");
        if (rden0 && ax0.tvalid) flag("rden0_during_packet");
        rd0 = rden0;
        rd1 = rden1;
        mv0 = ax0.tvalid;
        if (pv0 && !pr0) begin
            check("stall_tvalid", {31'd0, ax0.tvalid}, 32'd1);
            check("stall_tdata", ax0.tdata, pdata0);
            check("stall_tlast", {31'd0, ax0.tlast}, {31'd0, plast0});
        end
        if (ax0.tvalid && ax0.tready) begin
            score(0, ax0.tdata, ax0.tlast);
            hs0++;
        end
        if (ax1.tvalid && ax1.tready) begin
            score(1, ax1.tdata, ax1.tlast);
            hs1++;
        end
        pv0 = ax0.tvalid; pr0 = ax0.tready; pdata0 = ax0.tdata; plast0 = ax0.tlast;
        @(posedge clk);
        #1;
        if (rd0 && fq0.size() != 0) rdata0 = fq0.pop_front();
        if (rd1 && fq1.size() != 0) rdata1 = fq1.pop_front();
        empty0 = (fq0.size() == 0);
        empty1 = (fq1.size() == 0);
        if (!bp) begin
            ax0.tready = 1'b1;
        end else if (ax0.tvalid) begin
            if (stall == 5) begin
                ax0.tready = 1'b1;
                stall = 0;
            end else begin
                ax0.tready = 1'b0;
                stall++;
            end
        end else begin
            ax0.tready = 1'b0;
            stall = 0;
        end
    endtask

    task automatic push_word(input int inst, input logic [AW-1:0] w);
        if (inst == 0) begin
            fq0.push_back(w);
            empty0 = 1'b0;
        end else begin
            fq1.push_back(w);
            empty1 = 1'b0;
        end
    endtask

    task automatic push_exp(input int inst, input logic [AW-1:0] qid, input logic [AW-1:0] pos,
                            input logic [AW-1:0] third);
        beat_t b [3];
        b[0] = '{qid, 1'b0};
        b[1] = '{pos, 1'b0};
        b[2] = '{third, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (inst == 0) exp0.push_back(b[i]);
            else exp1.push_back(b[i]);
        end
    endtask

    task automatic wait_idle(input int inst, input string name);
        int n = 0;
        tick();
        while (n < 300 && ((inst == 0) ? (exp0.size() != 0 || busy0) : (exp1.size() != 0 || busy1))) begin
            tick();
            n++;
        end
        if (n >= 300) flag({name, "_timeout"});
        check({name, "_busy_idle"}, {31'd0, (inst == 0) ? busy0 : busy1}, 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        int n, lat, pk;
        vecs[0] = '{32'd7,  32'd1234, 32'd40,          16'd50,     32'h8000_0028};
        vecs[1] = '{32'd7,  32'd1234, 32'd60,          16'd50,     32'h0000_003C};
        vecs[2] = '{32'd1,  32'd2,    32'h0000_FFFF,   16'hFFFF,   32'h8000_FFFF};
        vecs[3] = '{32'd3,  32'd4,    32'd0,           16'd0,      32'h8000_0000};
        vecs[4] = '{32'd5,  32'd6,    32'd1,           16'd0,      32'h0000_0001};
        vecs[5] = '{32'd10, 32'd11,   32'hABCD_0010,   16'h0020,   32'h8000_0010};
        vecs[6] = '{32'd12, 32'd13,   32'h0000_0021,   16'h0020,   32'h0000_0021};
        vecs[7] = '{32'd14, 32'd15,   32'h0000_1234,   16'hFFFF,   32'h8000_1234};
        vecs[8] = '{32'd16, 32'd17,   32'hFFFF_0005,   16'd4,      32'h0000_0005};

        ax0.tready = 1'b1;
        ax1.tready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_rden", {31'd0, rden0}, 32'd0);
        check("rst_tvalid", {31'd0, ax0.tvalid}, 32'd0);
        check("rst_tlast", {31'd0, ax0.tlast}, 32'd0);
        check("rst_tdata", ax0.tdata, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
`ifdef DTW_RESULT_STATS_EN
        check("rst_hit_count", hit1, 32'd0);
        check("rst_miss_count", miss1, 32'd0);
`endif
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // Table-driven records with the FIFO preloaded and tready high.
        for (int v = 0; v < 9; v++) begin
            threshold = vecs[v].thr;
            push_word(0, vecs[v].qid);
            push_word(0, vecs[v].pos);
            push_word(0, vecs[v].mword);
            push_exp(0, vecs[v].qid, vecs[v].pos, vecs[v].third);
            n = 0;
            do begin tick(); n++; end while (!rd0 && n < 20);
            check($sformatf("vec%0d_rden_seen", v), {31'd0, rd0}, 32'd1);
            lat = 0;
            do begin tick(); lat++; end while (!mv0 && lat < 20);
            check($sformatf("vec%0d_latency", v), lat, 32'd5);
            pk = 0;
            while (mv0 && pk < 10) begin pk++; tick(); end
            check($sformatf("vec%0d_pkt_cycles", v), pk, 32'd3);
            wait_idle(0, $sformatf("vec%0d", v));
        end

        // Starved FIFO between words 1 and 2.
        threshold = 16'd50;
        push_word(0, 32'd11);
        repeat (10) tick();
        check("starve_busy", {31'd0, busy0}, 32'd1);
        check("starve_no_beat", {31'd0, ax0.tvalid}, 32'd0);
        push_word(0, 32'd12);
        push_word(0, 32'd30);
        push_exp(0, 32'd11, 32'd12, 32'h8000_001E);
        wait_idle(0, "starve");

        // Backpressure: five stall cycles on every beat.
        bp = 1'b1;
        hs0 = 0;
        push_word(0, 32'd13);
        push_word(0, 32'd14);
        push_word(0, 32'd45);
        push_exp(0, 32'd13, 32'd14, 32'h8000_002D);
        wait_idle(0, "backpressure");
        check("bp_handshakes", hs0, 32'd3);
        bp = 1'b0;
        tick();

        // Reset after the qid has been captured.
        push_word(0, 32'd99);
        n = 0;
        do begin tick(); n++; end while (!busy0 && n < 20);
        repeat (2) tick();
        check("midrec_busy", {31'd0, busy0}, 32'd1);
        enable = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_rden", {31'd0, rden0}, 32'd0);
        check("midrst_tvalid", {31'd0, ax0.tvalid}, 32'd0);
        check("midrst_tlast", {31'd0, ax0.tlast}, 32'd0);
        check("midrst_tdata", ax0.tdata, 32'd0);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;
        enable = 1'b1;
        push_word(0, 32'd9);
        push_word(0, 32'd5);
        push_word(0, 32'd3);
        push_exp(0, 32'd9, 32'd5, 32'h8000_0003);
        wait_idle(0, "post_reset");

        // enable dropped right after the first rden of a record.
        push_word(0, 32'd21); push_word(0, 32'd22); push_word(0, 32'd10);
        push_word(0, 32'd23); push_word(0, 32'd24); push_word(0, 32'd70);
        push_exp(0, 32'd21, 32'd22, 32'h8000_000A);
        n = 0;
        do begin tick(); n++; end while (!rd0 && n < 20);
        enable = 1'b0;
        wait_idle(0, "en_drop");
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd0 || busy0) n++;
        end
        check("en_drop_stays_idle", n, 32'd0);
        check("en_drop_fifo_left", fq0.size(), 32'd3);
        push_exp(0, 32'd23, 32'd24, 32'h0000_0046);
        enable = 1'b1;
        wait_idle(0, "en_resume");

        // DROP_MISS=1 instance: miss vanishes, hit is emitted.
        threshold = 16'd50;
        hs1 = 0;
        push_word(1, 32'd30); push_word(1, 32'd31); push_word(1, 32'd60);
        n = 0;
        do begin tick(); n++; end while (!busy1 && n < 20);
        wait_idle(1, "drop_miss");
        check("drop_miss_no_beats", hs1, 32'd0);
`ifdef DTW_RESULT_STATS_EN
        check("drop_miss_count", miss1, 32'd1);
        check("drop_hit_count0", hit1, 32'd0);
`endif
        push_word(1, 32'd32); push_word(1, 32'd33); push_word(1, 32'd10);
        push_exp(1, 32'd32, 32'd33, 32'h8000_000A);
        wait_idle(1, "drop_hit");
        check("drop_hit_beats", hs1, 32'd3);
`ifdef DTW_RESULT_STATS_EN
        check("drop_hit_count1", hit1, 32'd1);
`endif
        check("exp0_drained", exp0.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
